// File: rtl/pipelinestages_pkg.sv
// Shared pipeline-stage types: the fetch entry that feeds the IF/ID register.
// PC storage is sized for the widest supported XLEN; narrower cores use the low bits.
package pipelinestages_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-IF/ID decoupling queue: circular buffer, 1-cycle enq->deq latency (0 with BYPASS on empty).
// Valid/ready on both sides; enq_ready drops when full or flushing, flush empties the queue.
module fetch_queue
  import pipelinestages_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [XLEN-1:0]              enq_pc,
  input  logic [31:0]                  enq_instr,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [XLEN-1:0]              deq_pc,
  output logic [31:0]                  deq_instr,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic          live;
  logic          empty;
  logic          enq_fire;
  logic          deq_fire;
  logic          pass;
  logic          wr_en;
  logic          rd_en;

  assign empty     = (occ == '0);
  assign head      = mem[rd_ptr];
  // live holds both handshakes low during reset and until the first edge after release.
  assign enq_ready = live && (occ < CW'(DEPTH)) && !flush;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;
  assign wr_en     = enq_fire && !pass;
  assign rd_en     = deq_fire && !pass;
  assign count     = occ;

  generate
    if (BYPASS != 0) begin : g_bypass
      assign deq_valid = live && !flush && (empty ? enq_valid : 1'b1);
      assign deq_pc    = empty ? enq_pc    : head.pc[XLEN-1:0];
      assign deq_instr = empty ? enq_instr : head.instr;
      // An entry consumed in the same cycle it arrives never touches storage.
      assign pass      = empty && enq_fire && deq_fire;
    end else begin : g_registered
      assign deq_valid = live && !flush && !empty;
      assign deq_pc    = head.pc[XLEN-1:0];
      assign deq_instr = head.instr;
      assign pass      = 1'b0;
    end

    if (XLEN < PC_W) begin : g_pc_pad
      logic unused_pc_hi;
      assign unused_pc_hi = ^head.pc[PC_W-1:XLEN];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= '{pc: PC_W'(enq_pc), instr: enq_instr};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (wr_en && !rd_en) begin
        occ <= occ + CW'(1);
      end else if (!wr_en && rd_en) begin
        occ <= occ - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a registered instance (BYPASS=0) and a bypass instance (BYPASS=1).
module tb_fetch_queue;

  logic        clk;
  logic        rst;

  logic        enq_valid, enq_ready, deq_valid, deq_ready, flush;
  logic [31:0] enq_pc, enq_instr, deq_pc, deq_instr;
  logic [2:0]  count;

  logic        b_enq_valid, b_enq_ready, b_deq_valid, b_deq_ready, b_flush;
  logic [31:0] b_enq_pc, b_enq_instr, b_deq_pc, b_deq_instr;
  logic [2:0]  b_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(.XLEN(32), .DEPTH(4), .BYPASS(0)) u_dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc), .enq_instr(enq_instr),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc), .deq_instr(deq_instr),
    .flush(flush), .count(count)
  );

  fetch_queue #(.XLEN(32), .DEPTH(4), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst),
    .enq_valid(b_enq_valid), .enq_ready(b_enq_ready), .enq_pc(b_enq_pc), .enq_instr(b_enq_instr),
    .deq_valid(b_deq_valid), .deq_ready(b_deq_ready), .deq_pc(b_deq_pc), .deq_instr(b_deq_instr),
    .flush(b_flush), .count(b_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    enq_valid = 1'b1;
    enq_pc    = pc;
    enq_instr = instr;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    enq_valid = 1'b1; enq_pc = 32'h0; enq_instr = 32'h0; deq_ready = 1'b0; flush = 1'b0;
    b_enq_valid = 1'b1; b_enq_pc = 32'h0; b_enq_instr = 32'h0; b_deq_ready = 1'b0; b_flush = 1'b0;
    #22;
    n_checks++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL reset_enq_ready: got %b want 0", enq_ready); end
    n_checks++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_deq_valid: got %b want 0", deq_valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (deq_pc !== 32'h0 || deq_instr !== 32'h0) begin n_fail++; $display("FAIL reset_deq_data: got %h/%h want 0/0", deq_pc, deq_instr); end
    n_checks++; if (b_deq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_byp_deq_valid: got %b want 0", b_deq_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL release_before_edge: got %b want 0", enq_ready); end
    tick();
    n_checks++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL release_enq_ready: got %b want 1", enq_ready); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL release_count: got %0d want 0", count); end
    enq_valid = 1'b0;
    b_enq_valid = 1'b0;
  endtask

  task automatic test_fill_drain();
    deq_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(32'(4 * i), 32'hA000_0000 + 32'(i));
      n_checks++; if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
      n_checks++; if (deq_valid !== 1'b1) begin n_fail++; $display("FAIL fill_deq_valid[%0d]: got %b want 1", i, deq_valid); end
    end
    n_checks++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL full_enq_ready: got %b want 0", enq_ready); end
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (deq_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL drain_pc[%0d]: got %h want %h", i, deq_pc, 4 * i); end
      n_checks++; if (deq_instr !== 32'hA000_0000 + 32'(i)) begin n_fail++; $display("FAIL drain_instr[%0d]: got %h want %h", i, deq_instr, 32'hA000_0000 + 32'(i)); end
      tick();
    end
    deq_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", count); end
    n_checks++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL drain_deq_valid: got %b want 0", deq_valid); end
  endtask

  task automatic test_concurrent_wrap();
    logic [31:0] next_pc;
    logic [31:0] want;
    deq_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h100 + 32'(4 * i), (32'h100 + 32'(4 * i)) ^ 32'h5A5A_0000);
    next_pc = 32'h10C;
    for (int k = 0; k < 10; k++) begin
      enq_valid = 1'b1; enq_pc = next_pc; enq_instr = next_pc ^ 32'h5A5A_0000; deq_ready = 1'b1;
      #1;
      want = 32'h100 + 32'(4 * k);
      n_checks++; if (deq_pc !== want || deq_instr !== (want ^ 32'h5A5A_0000)) begin n_fail++; $display("FAIL conc_head[%0d]: got %h/%h want %h/%h", k, deq_pc, deq_instr, want, want ^ 32'h5A5A_0000); end
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL conc_count[%0d]: got %0d want 3", k, count); end
      n_checks++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL conc_enq_ready[%0d]: got %b want 1", k, enq_ready); end
      tick();
      next_pc = next_pc + 32'h4;
    end
    enq_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      want = 32'h128 + 32'(4 * j);
      n_checks++; if (deq_pc !== want || deq_instr !== (want ^ 32'h5A5A_0000)) begin n_fail++; $display("FAIL conc_tail[%0d]: got %h/%h want %h/%h", j, deq_pc, deq_instr, want, want ^ 32'h5A5A_0000); end
      tick();
    end
    deq_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL conc_final_count: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    deq_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i));
    flush = 1'b1; enq_valid = 1'b1; enq_pc = 32'h300; enq_instr = 32'hDEAD_0300;
    #1;
    n_checks++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL flush_enq_ready: got %b want 0", enq_ready); end
    n_checks++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL flush_deq_valid_now: got %b want 0", deq_valid); end
    tick();
    flush = 1'b0; enq_valid = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end
    n_checks++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL flush_deq_valid: got %b want 0", deq_valid); end
    push(32'h400, 32'hC000_0400);
    n_checks++; if (deq_pc !== 32'h400 || count !== 3'd1) begin n_fail++; $display("FAIL post_flush_head: got %h cnt %0d want 400 cnt 1", deq_pc, count); end
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
  endtask

  task automatic test_stall();
    push(32'h500, 32'hE000_0500);
    push(32'h504, 32'hE000_0504);
    deq_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (deq_pc !== 32'h500 || deq_instr !== 32'hE000_0500) begin n_fail++; $display("FAIL stall_head[%0d]: got %h/%h want 500/e0000500", i, deq_pc, deq_instr); end
      n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL stall_count[%0d]: got %0d want 2", i, count); end
      tick();
    end
    deq_ready = 1'b1;
    tick();
    n_checks++; if (deq_pc !== 32'h504 || count !== 3'd1) begin n_fail++; $display("FAIL stall_release: got %h cnt %0d want 504 cnt 1", deq_pc, count); end
    tick();
    deq_ready = 1'b0;
  endtask

  task automatic test_bypass();
    b_enq_valid = 1'b1; b_enq_pc = 32'h100; b_enq_instr = 32'hCAFE_0100; b_deq_ready = 1'b1;
    #1;
    n_checks++; if (b_deq_valid !== 1'b1) begin n_fail++; $display("FAIL byp_deq_valid: got %b want 1", b_deq_valid); end
    n_checks++; if (b_deq_pc !== 32'h100 || b_deq_instr !== 32'hCAFE_0100) begin n_fail++; $display("FAIL byp_data: got %h/%h want 100/cafe0100", b_deq_pc, b_deq_instr); end
    tick();
    n_checks++; if (b_count !== 3'd0) begin n_fail++; $display("FAIL byp_count: got %0d want 0", b_count); end
    b_deq_ready = 1'b0; b_enq_pc = 32'h200; b_enq_instr = 32'hCAFE_0200;
    tick();
    n_checks++; if (b_count !== 3'd1 || b_deq_pc !== 32'h200) begin n_fail++; $display("FAIL byp_stored: got %h cnt %0d want 200 cnt 1", b_deq_pc, b_count); end
    b_enq_pc = 32'h204; b_enq_instr = 32'hCAFE_0204; b_deq_ready = 1'b1;
    #1;
    n_checks++; if (b_deq_pc !== 32'h200) begin n_fail++; $display("FAIL byp_head_priority: got %h want 200", b_deq_pc); end
    tick();
    n_checks++; if (b_count !== 3'd1 || b_deq_pc !== 32'h204) begin n_fail++; $display("FAIL byp_concurrent: got %h cnt %0d want 204 cnt 1", b_deq_pc, b_count); end
    b_enq_valid = 1'b0;
    tick();
    b_deq_ready = 1'b0;
    b_flush = 1'b1; b_enq_valid = 1'b1; b_enq_pc = 32'h300;
    #1;
    n_checks++; if (b_deq_valid !== 1'b0 || b_count !== 3'd0) begin n_fail++; $display("FAIL byp_flush: got valid %b cnt %0d want 0 cnt 0", b_deq_valid, b_count); end
    tick();
    b_flush = 1'b0; b_enq_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    deq_ready = 1'b0;
    push(32'h600, 32'hF000_0600);
    push(32'h604, 32'hF000_0604);
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || deq_valid !== 1'b0 || enq_ready !== 1'b0) begin n_fail++; $display("FAIL async_reset: got cnt %0d valid %b ready %b want 0 0 0", count, deq_valid, enq_ready); end
    n_checks++; if (deq_pc !== 32'h0 || deq_instr !== 32'h0) begin n_fail++; $display("FAIL async_reset_data: got %h/%h want 0/0", deq_pc, deq_instr); end
    #3;
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_concurrent_wrap();
    test_flush();
    test_stall();
    test_bypass();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
